// File: rtl/hex_word_printer.sv
// Queued hex-dump engine: prints 32-bit words as ASCII hex characters into the text controller.
// Define HEX_PRINT_PREFIX_EN to prepend "0x" to every printed word (10 characters instead of 8).
module hex_word_printer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 60,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [23:0] ATTR       = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_word,
  input  logic [5:0]  req_row,
  input  logic [6:0]  req_col,
  output logic        busy,
  output logic        done,
  output logic        ascii_write_en,
  output logic [12:0] ascii_write_address,
  output logic [31:0] ascii_input
);

`ifdef HEX_PRINT_PREFIX_EN
  localparam int NCHAR = 10;
`else
  localparam int NCHAR = 8;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, GAP, FINISH} state_t;

  logic [31:0]      fifoWord_q [FIFO_DEPTH];
  logic [5:0]       fifoRow_q  [FIFO_DEPTH];
  logic [6:0]       fifoCol_q  [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  state_t      state_q;
  logic [31:0] word_q;
  logic [5:0]  row_q;
  logic [6:0]  col_q;
  logic [3:0]  idx_q;
  logic [12:0] base_q;
  logic        writeEn_q, done_q;
  logic [12:0] addr_q;
  logic [31:0] data_q;

  logic [12:0] baseCalc;
  logic [3:0]  emitIdx_d;
  logic [12:0] emitAddr_d;
  logic        emitEn_d;
  logic [7:0]  emitChar_d;

  function automatic logic [7:0] digitChar(input logic [31:0] w, input logic [2:0] k);
    logic [2:0]  d;
    logic [31:0] sh;
    d  = 3'd7 - k;
    sh = w >> {d, 2'b00};
    return (sh[3:0] < 4'd10) ? (8'h30 + {4'h0, sh[3:0]}) : (8'h37 + {4'h0, sh[3:0]});
  endfunction

  function automatic logic [7:0] charFor(input logic [31:0] w, input logic [3:0] idx);
    logic [7:0] c;
    logic [3:0] k;
`ifdef HEX_PRINT_PREFIX_EN
    k = idx - 4'd2;
    if (idx == 4'd0)      c = 8'h30;
    else if (idx == 4'd1) c = 8'h78;
    else                  c = digitChar(w, k[2:0]);
`else
    k = idx;
    c = digitChar(w, k[2:0]);
`endif
    return c;
  endfunction

  assign req_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign busy      = (count_q != '0) || (state_q != IDLE);

  assign done                = done_q;
  assign ascii_write_en      = writeEn_q;
  assign ascii_write_address = addr_q;
  assign ascii_input         = data_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoWord_q[wrPtr_q] <= req_word;
      fifoRow_q[wrPtr_q]  <= req_row;
      fifoCol_q[wrPtr_q]  <= req_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Everything needed for the next character write, whether entered from LOAD (i=0) or GAP (i+1).
  always_comb begin
    baseCalc   = 13'(row_q) * 13'(COLS) + 13'(col_q);
    emitIdx_d  = (state_q == GAP) ? idx_q + 4'd1 : 4'd0;
    emitAddr_d = ((state_q == LOAD) ? baseCalc : base_q) + 13'(emitIdx_d);
    emitEn_d   = (int'(col_q) + int'(emitIdx_d)) < COLS;
    emitChar_d = charFor(word_q, emitIdx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      base_q    <= '0;
      writeEn_q <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      writeEn_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            word_q  <= fifoWord_q[rdPtr_q];
            row_q   <= fifoRow_q[rdPtr_q];
            col_q   <= fifoCol_q[rdPtr_q];
            idx_q   <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          base_q <= baseCalc;
          if (int'(row_q) >= ROWS) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            writeEn_q <= emitEn_d;
            addr_q    <= emitAddr_d;
            data_q    <= {emitChar_d, ATTR};
            state_q   <= EMIT;
          end
        end
        EMIT: state_q <= GAP;
        GAP: begin
          if (idx_q == 4'(NCHAR - 1)) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            idx_q     <= emitIdx_d;
            writeEn_q <= emitEn_d;
            addr_q    <= emitAddr_d;
            data_q    <= {emitChar_d, ATTR};
            state_q   <= EMIT;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
